// File: rtl/lcg_rng_param.sv
// Parametrised LCG random-number source: free-runs in RUN, captures on STOP, with a valid/strobe handshake.
// Optional iterative range reduction of the captured value is enabled with `define LCG_RANGE_EN.
module lcg_rng_param #(
  parameter int WIDTH = 8,
  parameter int A     = 5,
  parameter int C     = 1,
  parameter int SEED  = 6,
  parameter int RANGE = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       state,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] random_num,
  output logic             rnd_valid,
  output logic             rnd_strobe,
  output logic             period_wrap
);

  localparam int              PW     = 2 * WIDTH;
  localparam logic [PW-1:0]   A_EXT  = PW'(A);
  localparam logic [PW-1:0]   C_EXT  = PW'(C);
  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

  if (RANGE < 1 || RANGE >= 2 ** WIDTH) begin : g_range_chk
    $error("lcg_rng_param: RANGE must lie in 1..2**WIDTH-1");
  end

  typedef enum logic [1:0] {
    CMD_STOP = 2'd0,
    CMD_RUN  = 2'd1,
    CMD_LOAD = 2'd2,
    CMD_HOLD = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
`ifdef LCG_RANGE_EN
    REDUCE = 2'd2,
`endif
    DONE   = 2'd3
  } fsm_e;

  cmd_e             cmd;
  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] num_q, num_d;
  logic             valid_q, valid_d;
  logic             strobe_q, strobe_d;
  logic             wrap_q, wrap_d;
`ifdef LCG_RANGE_EN
  localparam logic [WIDTH-1:0] RANGE_W = WIDTH'(RANGE);
  logic [WIDTH-1:0] red_q, red_d;
`endif

  assign cmd = cmd_e'(state);
  // Full double-width product, truncated to the modulus 2**WIDTH.
  assign nxt = WIDTH'(A_EXT * {{WIDTH{1'b0}}, cur_q} + C_EXT);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    fsm_d    = fsm_q;
    cur_d    = cur_q;
    seed_d   = seed_q;
    num_d    = num_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    wrap_d   = 1'b0;
`ifdef LCG_RANGE_EN
    red_d    = red_q;
`endif

    unique case (cmd)
      CMD_RUN: begin
        cur_d   = nxt;
        fsm_d   = RUN;
        valid_d = 1'b0;
        wrap_d  = (nxt == seed_q);
      end
      CMD_LOAD: begin
        cur_d   = seed_in;
        seed_d  = seed_in;
        fsm_d   = IDLE;
        valid_d = 1'b0;
      end
      CMD_STOP: begin
        if (fsm_q == RUN) begin
`ifdef LCG_RANGE_EN
          red_d = cur_q;
          fsm_d = REDUCE;
`else
          num_d    = cur_q;
          valid_d  = 1'b1;
          strobe_d = 1'b1;
          fsm_d    = DONE;
`endif
        end
      end
      default: ;  // HOLD: generator frozen, FSM unchanged
    endcase

`ifdef LCG_RANGE_EN
    // Reduction keeps going through STOP and HOLD; RUN and LOAD abort it above.
    if (fsm_q == REDUCE && (cmd == CMD_STOP || cmd == CMD_HOLD)) begin
      if (red_q >= RANGE_W) begin
        red_d = red_q - RANGE_W;
      end else begin
        num_d    = red_q;
        valid_d  = 1'b1;
        strobe_d = 1'b1;
        fsm_d    = DONE;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      cur_q    <= SEED_W;
      seed_q   <= SEED_W;
      num_q    <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      wrap_q   <= 1'b0;
`ifdef LCG_RANGE_EN
      red_q    <= '0;
`endif
    end else begin
      fsm_q    <= fsm_d;
      cur_q    <= cur_d;
      seed_q   <= seed_d;
      num_q    <= num_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      wrap_q   <= wrap_d;
`ifdef LCG_RANGE_EN
      red_q    <= red_d;
`endif
    end
  end

  assign random_num  = num_q;
  assign rnd_valid   = valid_q;
  assign rnd_strobe  = strobe_q;
  assign period_wrap = wrap_q;

endmodule

// File: tb/tb_lcg_rng_param.sv
// Directed bench for lcg_rng_param (WIDTH=8, A=5, C=1, SEED=6, RANGE=10); expected values are hand-computed.
// Works in both builds; reduction latency and results follow `LCG_RANGE_EN.
module tb_lcg_rng_param;

  localparam int WIDTH = 8;
  localparam int RANGE = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       state;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] random_num;
  logic             rnd_valid;
  logic             rnd_strobe;
  logic             period_wrap;

  int vectors = 0;
  int errors  = 0;

  lcg_rng_param #(
    .WIDTH(WIDTH), .A(5), .C(1), .SEED(6), .RANGE(RANGE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state),
    .seed_in    (seed_in),
    .random_num (random_num),
    .rnd_valid  (rnd_valid),
    .rnd_strobe (rnd_strobe),
    .period_wrap(period_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // STOP after a RUN with raw generator value `raw`; checks the handshake and result timing.
  task automatic capture(input string tag, input int raw);
    int lat;
    int exp_num;
`ifdef LCG_RANGE_EN
    lat     = raw / RANGE + 1;
    exp_num = raw % RANGE;
`else
    lat     = 0;
    exp_num = raw;
`endif
    state = 2'd0;
    step(1);
    state = 2'd3;
    if (lat > 1) begin
      step(lat - 1);
      check({tag, "_valid_early"}, 32'(rnd_valid), 32'd0);
    end
    if (lat > 0) step(1);
    check({tag, "_num"},    32'(random_num), 32'(exp_num));
    check({tag, "_valid"},  32'(rnd_valid),  32'd1);
    check({tag, "_strobe"}, 32'(rnd_strobe), 32'd1);
    step(1);
    check({tag, "_strobe_1cyc"}, 32'(rnd_strobe), 32'd0);
    check({tag, "_valid_held"},  32'(rnd_valid),  32'd1);
  endtask

  initial begin
    int wraps;
    rst_n   = 1'b0;
    state   = 2'd3;
    seed_in = '0;
    #12;
    check("rst_num",    32'(random_num),  32'd0);
    check("rst_valid",  32'(rnd_valid),   32'd0);
    check("rst_strobe", 32'(rnd_strobe),  32'd0);
    check("rst_wrap",   32'(period_wrap), 32'd0);
    #10 rst_n = 1'b1;
    step(1);

    // STOP with no prior RUN must not capture.
    state = 2'd0;
    step(3);
    check("norun_valid",  32'(rnd_valid),  32'd0);
    check("norun_num",    32'(random_num), 32'd0);
    check("norun_strobe", 32'(rnd_strobe), 32'd0);

    // 6 -> 31 -> 156 -> 13
    state = 2'd1;
    step(3);
    capture("run3", 13);
    // STOP again while DONE has no effect.
    state = 2'd0;
    step(2);
    check("done_hold_strobe", 32'(rnd_strobe), 32'd0);
    check("done_hold_valid",  32'(rnd_valid),  32'd1);

    // Full period from seed 0: wrap exactly once, on step 256.
    state   = 2'd2;
    seed_in = 8'd0;
    step(1);
    check("load_clears_valid", 32'(rnd_valid), 32'd0);
    state = 2'd1;
    wraps = 0;
    for (int i = 1; i <= 256; i++) begin
      step(1);
      if (i < 256 && period_wrap) wraps++;
    end
    check("wrap_early_count", 32'(wraps), 32'd0);
    check("wrap_at_256",      32'(period_wrap), 32'd1);
    capture("period_cur0", 0);
    check("wrap_pulse_1cyc", 32'(period_wrap), 32'd0);

    // HOLD does not advance: RUN 2, HOLD 5, RUN 1 -> 13.
    state   = 2'd2;
    seed_in = 8'd6;
    step(1);
    state = 2'd1;
    step(2);
    state = 2'd3;
    step(5);
    check("hold_no_wrap", 32'(period_wrap), 32'd0);
    state = 2'd1;
    step(1);
    check("run_clears_valid", 32'(rnd_valid), 32'd0);
    capture("hold", 13);

    // RUN 2 from seed 6 -> 156.
    state = 2'd2;
    step(1);
    state = 2'd1;
    step(2);
    capture("cap156", 156);

`ifdef LCG_RANGE_EN
    // RUN during REDUCE aborts with no strobe; 156 would finish 16 cycles after capture.
    state = 2'd2;
    step(1);
    state = 2'd1;
    step(2);
    state = 2'd0;
    step(4);
    state = 2'd1;
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (rnd_strobe || rnd_valid) wraps++;
    end
    check("abort_no_strobe", 32'(wraps), 32'd0);
`endif

    // Async reset mid-operation (mid-REDUCE when enabled, mid-DONE otherwise).
    state = 2'd2;
    seed_in = 8'd6;
    step(1);
    state = 2'd1;
    step(2);
    state = 2'd0;
    step(5);
`ifndef LCG_RANGE_EN
    check("pre_rst_valid", 32'(rnd_valid), 32'd1);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_num",    32'(random_num), 32'd0);
    check("async_rst_valid",  32'(rnd_valid),  32'd0);
    check("async_rst_strobe", 32'(rnd_strobe), 32'd0);
    #3 rst_n = 1'b1;
    state = 2'd0;
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (rnd_strobe) wraps++;
    end
    check("post_rst_no_strobe", 32'(wraps), 32'd0);
    // cur restored to SEED: one RUN step gives 31.
    state = 2'd1;
    step(1);
    capture("post_rst", 31);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
